// File: rtl/mdu_ctrl.sv
// mdu_ctrl: multi-cycle multiply/divide unit controller with HI/LO registers
// and E-stage hazard stall generation.
// Optional feature macro: MDU_DIV_EN builds the DIV/DIVU datapath. When it
// is undefined, ops 2/3 are treated as reserved no-ops.
module mdu_ctrl #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        cancel,
    input  logic        md_use_D,
    output logic        busy,
    output logic        stall,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    localparam int unsigned DATA_W  = 32;
    localparam int unsigned MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int unsigned CNT_W   = $clog2(MAX_CYC + 1);

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_e;

    state_e              state_q;
    logic [CNT_W-1:0]    cnt_q;
    logic [2:0]          op_q;
    logic [DATA_W-1:0]   a_q;
    logic [DATA_W-1:0]   b_q;
    logic [DATA_W-1:0]   hi_q;
    logic [DATA_W-1:0]   lo_q;

    logic                accept_c;
    logic                long_op_c;
    logic [CNT_W-1:0]    load_cnt_c;
    logic                res_we_c;
    logic [DATA_W-1:0]   res_hi_c;
    logic [DATA_W-1:0]   res_lo_c;
    logic [2*DATA_W-1:0] prod_c;

    // Decode the incoming op: accepted-ness, multi-cycle class and busy length
    always_comb begin
        accept_c   = start & ~cancel & (state_q == S_IDLE);
        long_op_c  = 1'b0;
        load_cnt_c = CNT_W'(MULT_CYCLES);
        case (op)
            OP_MULT, OP_MULTU: long_op_c = 1'b1;
`ifdef MDU_DIV_EN
            OP_DIV, OP_DIVU: begin
                long_op_c  = 1'b1;
                load_cnt_c = CNT_W'(DIV_CYCLES);
            end
`endif
            default: long_op_c = 1'b0;
        endcase
    end

    // Result datapath on the latched operands, consumed at the completion edge
    always_comb begin
        res_we_c = 1'b0;
        res_hi_c = hi_q;
        res_lo_c = lo_q;
        prod_c   = '0;
        case (op_q)
            OP_MULT: begin
                prod_c   = {{DATA_W{a_q[DATA_W-1]}}, a_q} * {{DATA_W{b_q[DATA_W-1]}}, b_q};
                res_we_c = 1'b1;
                res_hi_c = prod_c[2*DATA_W-1:DATA_W];
                res_lo_c = prod_c[DATA_W-1:0];
            end
            OP_MULTU: begin
                prod_c   = {{DATA_W{1'b0}}, a_q} * {{DATA_W{1'b0}}, b_q};
                res_we_c = 1'b1;
                res_hi_c = prod_c[2*DATA_W-1:DATA_W];
                res_lo_c = prod_c[DATA_W-1:0];
            end
`ifdef MDU_DIV_EN
            // Divide by zero leaves HI/LO untouched after the full busy period
            OP_DIV: begin
                if (b_q != '0) begin
                    res_we_c = 1'b1;
                    res_lo_c = DATA_W'($signed(a_q) / $signed(b_q));
                    res_hi_c = DATA_W'($signed(a_q) % $signed(b_q));
                end
            end
            OP_DIVU: begin
                if (b_q != '0) begin
                    res_we_c = 1'b1;
                    res_lo_c = a_q / b_q;
                    res_hi_c = a_q % b_q;
                end
            end
`endif
            default: res_we_c = 1'b0;
        endcase
    end

    // Control FSM, operand latches, countdown and HI/LO architectural state
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (accept_c) begin
                        if (long_op_c) begin
                            op_q    <= op;
                            a_q     <= A;
                            b_q     <= B;
                            cnt_q   <= load_cnt_c;
                            state_q <= S_RUN;
                        end else if (op == OP_MTHI) begin
                            hi_q <= A;
                        end else if (op == OP_MTLO) begin
                            lo_q <= A;
                        end
                    end
                end
                S_RUN: begin
                    if (cnt_q == CNT_W'(1)) begin
                        if (res_we_c) begin
                            hi_q <= res_hi_c;
                            lo_q <= res_lo_c;
                        end
                        cnt_q   <= '0;
                        state_q <= S_IDLE;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // Busy decodes the state register; stall blocks a D-stage MDU user behind a long op
    always_comb begin
        busy  = (state_q == S_RUN);
        stall = md_use_D & (busy | (start & ~cancel & long_op_c));
        HI    = hi_q;
        LO    = lo_q;
    end

endmodule
